// File: rtl/xz_to_affine_if.sv
// Request/response bundle between the ladder point-add stage and the affine converter.
// The requester drives start/X_in/Z_in; the converter returns x_out/busy/done/err.
interface xz_to_affine_if #(
    parameter int WIDTH = 256
);
    logic             start;
    logic [WIDTH-1:0] X_in;
    logic [WIDTH-1:0] Z_in;
    logic [WIDTH-1:0] x_out;
    logic             busy;
    logic             done;
    logic             err;

    modport master (output start, X_in, Z_in, input x_out, busy, done, err);
    modport slave  (input start, X_in, Z_in, output x_out, busy, done, err);
endinterface

// File: rtl/xz_to_affine.sv
// Projective (X:Z) to affine x = X * Z^(P-2) mod P, using Fermat inversion.
// A single digit-serial modular multiplier is shared by every square/multiply step.

module mul_mod_p #(
    parameter int               WIDTH = 256,
    parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF,
    parameter int               DIGIT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] ab_o,
    output logic             done_o
);
    localparam int SW    = WIDTH + DIGIT + 1;
    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CW    = $clog2(NSTEP);
    // 2^WIDTH mod P; small enough that two folds plus one subtract fully reduce
    localparam logic [WIDTH:0] DELTA = {1'b1, {WIDTH{1'b0}}} - {1'b0, P};

    logic [WIDTH-1:0] a_q, b_q, r_q, r_d;
    logic [CW-1:0]    cnt_q;
    logic             run_q, done_q;
    logic [SW-1:0]    sum, fold1;
    logic [WIDTH:0]   fold2;

    // Horner step over b, most significant digit first: r = r*2^D + a*digit (mod P)
    always_comb begin
        sum   = (SW'(r_q) << DIGIT) + SW'(a_q) * SW'(b_q[WIDTH-1 -: DIGIT]);
        fold1 = SW'(sum[WIDTH-1:0]) + SW'(sum[SW-1:WIDTH]) * SW'(DELTA);
        fold2 = (WIDTH+1)'(fold1[WIDTH-1:0]) + (WIDTH+1)'(fold1[SW-1:WIDTH]) * DELTA;
        r_d   = (fold2 >= {1'b0, P}) ? WIDTH'(fold2 - {1'b0, P}) : fold2[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (!start_i) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (!run_q && !done_q) begin
            a_q   <= a_i;
            b_q   <= b_i;
            r_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            r_q   <= r_d;
            b_q   <= b_q << DIGIT;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(NSTEP - 1)) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign ab_o   = r_q;
    assign done_o = done_q;
endmodule

module xz_to_affine #(
    parameter int               WIDTH = 256,
    parameter logic [WIDTH-1:0] P     = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xz_to_affine_if.slave        bus
);
    localparam int               IW  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] EXP = P - WIDTH'(2);

    typedef enum logic [2:0] {IDLE, CHK, SQR, MUL, FIN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, z_q, z_d, acc_q, acc_d, res_q, res_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             err_q, err_d, mstart_q, mstart_d;
    logic [WIDTH-1:0] mul_a, mul_b, mul_ab;
    logic             mul_done;

    mul_mod_p #(.WIDTH(WIDTH), .P(P)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_i     (mul_a),
        .b_i     (mul_b),
        .start_i (mstart_q),
        .ab_o    (mul_ab),
        .done_o  (mul_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            z_q      <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            mstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            z_q      <= z_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            mstart_q <= mstart_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        z_d      = z_q;
        acc_d    = acc_q;
        res_d    = res_q;
        idx_d    = idx_q;
        err_d    = err_q;
        mstart_d = mstart_q;
        mul_a    = acc_q;
        mul_b    = acc_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    x_d     = bus.X_in;
                    z_d     = bus.Z_in;
                    res_d   = '0;
                    err_d   = 1'b0;
                    state_d = CHK;
                end
            end
            CHK: begin
                if (z_q == '0) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = DONE;
                end else begin
                    // exponent MSB is 1, so the first square-and-multiply reduces to acc = Z
                    acc_d    = z_q;
                    idx_d    = IW'(WIDTH - 2);
                    mstart_d = 1'b0;
                    state_d  = SQR;
                end
            end
            SQR, MUL, FIN: begin
                if (state_q == MUL) mul_b = z_q;
                if (state_q == FIN) mul_a = x_q;
                // one setup cycle with start low, then start held until the result lands
                if (!mstart_q) begin
                    mstart_d = 1'b1;
                end else if (mul_done) begin
                    mstart_d = 1'b0;
                    acc_d    = mul_ab;
                    case (state_q)
                        SQR: begin
                            if (EXP[idx_q])        state_d = MUL;
                            else if (idx_q == '0)  state_d = FIN;
                            else                   idx_d   = idx_q - IW'(1);
                        end
                        MUL: begin
                            if (idx_q == '0) state_d = FIN;
                            else begin
                                idx_d   = idx_q - IW'(1);
                                state_d = SQR;
                            end
                        end
                        default: begin
                            res_d   = mul_ab;
                            err_d   = 1'b0;
                            state_d = DONE;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.done  = (state_q == DONE);
    assign bus.busy  = (state_q == CHK) || (state_q == SQR) || (state_q == MUL) || (state_q == FIN);
    assign bus.x_out = res_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_xz_to_affine.sv
// Bench for xz_to_affine: vector table through a scoreboard, plus hand-written
// sequences for ignored starts, restart from DONE and mid-run reset.
module tb_xz_to_affine;
    localparam logic [255:0] P   = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] GX  = 256'h32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7;
    localparam logic [255:0] HALF = 256'h7FFFFFFF_7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_80000000_80000000_00000000;
    localparam int OPC = 9 + 2;          // multiplier latency L=9, plus setup and capture cycles
    localparam int LAT = 477 * OPC + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xz_to_affine_if #(.WIDTH(256)) bus();
    xz_to_affine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { logic [255:0] x; logic err; int lat; } exp_t;
    typedef struct { logic [255:0] x, z, xo; logic err; string nm; } vec_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned t0 = 0;
    int          mstarts = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge dut.mstart_q) mstarts++;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [255:0] xi, input logic [255:0] zi,
                          input logic [255:0] xo, input logic e, input string nm);
        exp_t ex;
        @(negedge clk);
        bus.X_in  = xi;
        bus.Z_in  = zi;
        bus.start = 1'b1;
        t0 = cyc;
        ex.x = xo; ex.err = e; ex.lat = e ? 2 : LAT;
        sb.push_back(ex);
        @(negedge clk);
        bus.start = 1'b0;
        bus.X_in  = ~xi;
        bus.Z_in  = ~zi;
        chk({nm, " busy after start"}, 256'(bus.busy), 256'(1));
        chk({nm, " done cleared"}, 256'(bus.done), 256'(0));
    endtask

    task automatic finish(input string nm);
        exp_t ex;
        while (!bus.done && (cyc - t0) < LAT + 40) @(negedge clk);
        chk({nm, " done"}, 256'(bus.done), 256'(1));
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", nm);
        end else begin
            ex = sb.pop_front();
            chk({nm, " latency"}, 256'(cyc - t0), 256'(ex.lat));
            chk({nm, " x_out"}, bus.x_out, ex.x);
            chk({nm, " err"}, 256'(bus.err), 256'(ex.err));
            chk({nm, " busy low"}, 256'(bus.busy), 256'(0));
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        exp_t dropped;
        int   m0;
        tbl[0] = '{GX,         256'd1,            GX,            1'b0, "gx/1"};
        tbl[1] = '{256'd2,     256'd2,            256'd1,        1'b0, "2/2"};
        tbl[2] = '{256'd1,     256'd2,            HALF,          1'b0, "1/2"};
        tbl[3] = '{256'd3,     P - 256'd1,        P - 256'd3,    1'b0, "3/p-1"};
        tbl[4] = '{256'd5,     256'd0,            256'd0,        1'b1, "z=0"};
        tbl[5] = '{256'd0,     256'd7,            256'd0,        1'b0, "x=0"};
        tbl[6] = '{GX,         GX,                256'd1,        1'b0, "gx/gx"};

        bus.start = 1'b0;
        bus.X_in  = '0;
        bus.Z_in  = '0;
        #2;
        chk("reset x_out", bus.x_out, 256'd0);
        chk("reset busy", 256'(bus.busy), 256'(0));
        chk("reset done", 256'(bus.done), 256'(0));
        chk("reset err", 256'(bus.err), 256'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            m0 = mstarts;
            launch(tbl[i].x, tbl[i].z, tbl[i].xo, tbl[i].err, tbl[i].nm);
            finish(tbl[i].nm);
            if (tbl[i].err) chk({tbl[i].nm, " mul starts"}, 256'(mstarts - m0), 256'(0));
        end

        // starts while busy are ignored; a start in DONE begins a fresh run
        launch(GX, 256'd1, GX, 1'b0, "busy-start");
        while ((cyc - t0) < 10) @(negedge clk);
        bus.X_in = 256'd2; bus.Z_in = 256'd2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ignored start @10 busy", 256'(bus.busy), 256'(1));
        while ((cyc - t0) < 500) @(negedge clk);
        bus.X_in = 256'd3; bus.Z_in = P - 256'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ignored start @500 busy", 256'(bus.busy), 256'(1));
        finish("busy-start");
        launch(256'd4, 256'd2, 256'd2, 1'b0, "restart");
        finish("restart");

        // reset in the middle of op 200 discards the request
        launch(GX, 256'd1, GX, 1'b0, "reset-mid");
        while ((cyc - t0) < 1 + 200 * OPC) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset x_out", bus.x_out, 256'd0);
        chk("mid reset busy", 256'(bus.busy), 256'(0));
        chk("mid reset done", 256'(bus.done), 256'(0));
        chk("mid reset err", 256'(bus.err), 256'(0));
        dropped = sb.pop_back();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post reset no done", 256'(bus.done), 256'(0));
        chk("post reset idle", 256'(bus.busy), 256'(0));
        chk("post reset mul start", 256'(dut.mstart_q), 256'(0));
        launch(GX, 256'd1, GX, 1'b0, "after-reset");
        finish("after-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
